axi_master_arbiter: RTL

AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

---
 rtl/axi_master_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: multiplexes N AXI3 masters onto one downstream AXI3 port.
// Reads: one request is offered at a time, picked round-robin. Each master may
// have one read outstanding, and R beats are steered back by rid.
// Writes: one write in flight at a time, run by a four-state FSM.
module axi_master_arbiter #(
    parameter int N_MASTERS  = 3,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clock,
    input  logic                               reset,

    // upstream read address / data
    input  logic [N_MASTERS-1:0]               s_ar_valid,
    output logic [N_MASTERS-1:0]               s_ar_ready,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]    s_ar_addr,
    input  logic [N_MASTERS*4-1:0]             s_ar_len,
    input  logic [N_MASTERS*3-1:0]             s_ar_size,
    output logic [N_MASTERS-1:0]               s_r_valid,
    input  logic [N_MASTERS-1:0]               s_r_ready,
    output logic [DATA_WIDTH-1:0]              s_r_data,
    output logic [1:0]                         s_r_resp,
    output logic                               s_r_last,

    // upstream write address / data / response
    input  logic [N_MASTERS-1:0]               s_aw_valid,
    output logic [N_MASTERS-1:0]               s_aw_ready,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]    s_aw_addr,
    input  logic [N_MASTERS*4-1:0]             s_aw_len,
    input  logic [N_MASTERS*3-1:0]             s_aw_size,
    input  logic [N_MASTERS-1:0]               s_w_valid,
    output logic [N_MASTERS-1:0]               s_w_ready,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]    s_w_data,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0]  s_w_strb,
    input  logic [N_MASTERS-1:0]               s_w_last,
    output logic [N_MASTERS-1:0]               s_b_valid,
    input  logic [N_MASTERS-1:0]               s_b_ready,
    output logic [1:0]                         s_b_resp,

    // downstream read address
    output logic [ID_WIDTH-1:0]                arid,
    output logic [ADDR_WIDTH-1:0]              araddr,
    output logic [3:0]                         arlen,
    output logic [2:0]                         arsize,
    output logic [1:0]                         arburst,
    output logic [1:0]                         arlock,
    output logic [3:0]                         arcache,
    output logic [2:0]                         arprot,
    output logic                               arvalid,
    input  logic                               arready,

    // downstream read data
    input  logic [ID_WIDTH-1:0]                rid,
    input  logic [DATA_WIDTH-1:0]              rdata,
    input  logic [1:0]                         rresp,
    input  logic                               rlast,
    input  logic                               rvalid,
    output logic                               rready,

    // downstream write address
    output logic [ID_WIDTH-1:0]                awid,
    output logic [ADDR_WIDTH-1:0]              awaddr,
    output logic [3:0]                         awlen,
    output logic [2:0]                         awsize,
    output logic [1:0]                         awburst,
    output logic [1:0]                         awlock,
    output logic [3:0]                         awcache,
    output logic [2:0]                         awprot,
    output logic                               awvalid,
    input  logic                               awready,

    // downstream write data
    output logic [ID_WIDTH-1:0]                wid,
    output logic [DATA_WIDTH-1:0]              wdata,
    output logic [DATA_WIDTH/8-1:0]            wstrb,
    output logic                               wlast,
    output logic                               wvalid,
    input  logic                               wready,

    // downstream write response
    input  logic [ID_WIDTH-1:0]                bid,
    input  logic [1:0]                         bresp,
    input  logic                               bvalid,
    output logic                               bready,

    output logic                               err_bad_id
);

    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    // Round-robin search starting just after 'last'.
    // The result is {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]     last);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        // Scan from the farthest candidate to the nearest, so the nearest wins.
        for (int k = N_MASTERS; k >= 1; k--) begin
            idx = (int'(last) + k) % N_MASTERS;
            if (req[IDX_W'(idx)]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    // read-path state
    logic [N_MASTERS-1:0] rd_pending;
    logic [N_MASTERS-1:0] rd_pending_next;
    logic [IDX_W-1:0]     rd_last;
    logic                 ar_hold;
    logic [IDX_W-1:0]     ar_gnt_q;
    logic [IDX_W-1:0]     ar_gnt;
    logic [IDX_W:0]       ar_pick;
    logic [N_MASTERS-1:0] r_oh;
    logic                 r_ok;
    logic                 r_bad;

    // write-path state
    w_state_t             w_state;
    w_state_t             w_next;
    logic [IDX_W-1:0]     wg;
    logic [IDX_W-1:0]     wg_next;
    logic [IDX_W-1:0]     wr_last;
    logic [IDX_W-1:0]     wr_last_next;
    logic [IDX_W:0]       aw_pick;
    logic [N_MASTERS-1:0] wg_oh;
    logic                 b_bad;

    // Burst attributes are fixed (INCR, normal access, no cache hints).
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'b0000;
    assign awcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awprot  = 3'b000;

    // The R and B payloads go to every master; only the valids are steered.
    assign s_r_data = rdata;
    assign s_r_resp = rresp;
    assign s_r_last = rlast;
    assign s_b_resp = bresp;

    assign awid = ID_WIDTH'(wg);
    assign wid  = ID_WIDTH'(wg);

    // AR grant.
    // While a request is being offered, the grant is frozen in ar_gnt_q.
    // Otherwise a new master is picked combinationally, so it appears in the
    // same cycle.
    always_comb begin
        ar_pick    = rr_pick(s_ar_valid & ~rd_pending, rd_last);
        ar_gnt     = ar_pick[IDX_W-1:0];
        arvalid    = ar_pick[IDX_W];
        araddr     = '0;
        arlen      = '0;
        arsize     = '0;
        s_ar_ready = '0;
        if (ar_hold) begin
            ar_gnt  = ar_gnt_q;
            arvalid = 1'b1;
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (ar_gnt == IDX_W'(i)) begin
                araddr        = s_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                arlen         = s_ar_len[i*4 +: 4];
                arsize        = s_ar_size[i*3 +: 3];
                s_ar_ready[i] = arvalid & arready;
            end
        end
        arid = ID_WIDTH'(ar_gnt);
    end

    // R routing by rid.
    // A beat whose rid is unknown, or has no read pending, is drained and
    // flagged as an error.
    always_comb begin
        r_oh = '0;
        r_ok = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (rid == ID_WIDTH'(i) && rd_pending[i]) begin
                r_oh[i] = 1'b1;
                r_ok    = 1'b1;
            end
        end
        s_r_valid = rvalid ? r_oh : '0;
        rready    = r_ok ? |(s_r_ready & r_oh) : rvalid;
        r_bad     = rvalid & ~r_ok;
    end

    // Next pending set.
    // The final R beat of a read frees its master, and an accepted AR marks
    // its master busy.
    always_comb begin
        rd_pending_next = rd_pending;
        if (rvalid && rready && rlast) begin
            rd_pending_next = rd_pending_next & ~r_oh;
        end
        if (arvalid && arready) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (ar_gnt == IDX_W'(i)) begin
                    rd_pending_next[i] = 1'b1;
                end
            end
        end
    end

    // Read control registers: pending set, round-robin pointer and AR hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pending <= '0;
            rd_last    <= IDX_W'(N_MASTERS - 1);
            ar_hold    <= 1'b0;
            ar_gnt_q   <= '0;
        end else begin
            rd_pending <= rd_pending_next;
            if (arvalid && arready) begin
                rd_last <= ar_gnt;
                ar_hold <= 1'b0;
            end else if (arvalid) begin
                ar_hold  <= 1'b1;
                ar_gnt_q <= ar_gnt;
            end
        end
    end

    // Select the fields of the granted write master, plus its one-hot mask.
    always_comb begin
        wg_oh  = '0;
        awaddr = '0;
        awlen  = '0;
        awsize = '0;
        wdata  = '0;
        wstrb  = '0;
        wlast  = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (wg == IDX_W'(i)) begin
                wg_oh[i] = 1'b1;
                awaddr   = s_aw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                awlen    = s_aw_len[i*4 +: 4];
                awsize   = s_aw_size[i*3 +: 3];
                wdata    = s_w_data[i*DATA_WIDTH +: DATA_WIDTH];
                wstrb    = s_w_strb[i*STRB_W +: STRB_W];
                wlast    = s_w_last[i];
            end
        end
    end

    // Write FSM next state and handshake outputs.
    // Each handshake signal is driven only in the state that owns it.
    always_comb begin
        w_next       = w_state;
        wg_next      = wg;
        wr_last_next = wr_last;
        aw_pick      = rr_pick(s_aw_valid, wr_last);
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        s_aw_ready   = '0;
        s_w_ready    = '0;
        s_b_valid    = '0;
        b_bad        = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_pick[IDX_W]) begin
                    wg_next = aw_pick[IDX_W-1:0];
                    w_next  = W_ADDR;
                end
            end
            W_ADDR: begin
                awvalid    = 1'b1;
                s_aw_ready = awready ? wg_oh : '0;
                if (awready) begin
                    w_next = W_DATA;
                end
            end
            W_DATA: begin
                wvalid    = |(s_w_valid & wg_oh);
                s_w_ready = wready ? wg_oh : '0;
                if (wvalid && wready && wlast) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                s_b_valid = bvalid ? wg_oh : '0;
                bready    = |(s_b_ready & wg_oh);
                if (bvalid && bready) begin
                    wr_last_next = wg;
                    w_next       = W_IDLE;
                    b_bad        = (bid != ID_WIDTH'(wg));
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM state register, granted master and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            wg      <= '0;
            wr_last <= IDX_W'(N_MASTERS - 1);
        end else begin
            w_state <= w_next;
            wg      <= wg_next;
            wr_last <= wr_last_next;
        end
    end

    // Sticky flag for unexpected rid or bid; cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_bad_id <= 1'b0;
        end else if (r_bad || b_bad) begin
            err_bad_id <= 1'b1;
        end
    end

endmodule
